// File: rtl/axi_skid_buffer_pkg.sv
// Shared types for the valid/ready skid buffer register slice.
// The occupancy state is exported so checkers can bind to it directly.
package axi_skid_buffer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic state_has_output(input skid_state_e s);
        return (s == ST_BUSY) || (s == ST_FULL);
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Fully registered valid/ready slice with one skid beat for the cycle after a stall.
// Handshake: a beat moves on a rising edge where valid and ready are both high; a
// producer holding valid high must keep its beat until it is taken.
module axi_skid_buffer
    import axi_skid_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_in,
    output skid_state_e           state_o
);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  in_xfer, out_xfer;

    // ready_out depends only on registered state, never on ready_in.
    assign ready_out = (state_q != ST_FULL) && !reset;
    assign valid_out = state_has_output(state_q);
    assign data_out  = out_data_q;
    assign state_o   = state_q;

    assign in_xfer  = valid_in && ready_out;
    assign out_xfer = valid_out && ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d    = ST_BUSY;
                    out_data_d = data_in;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    out_data_d = data_in;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    state_d     = ST_FULL;
                    skid_data_d = data_in;
                end
            end
            ST_FULL: begin
                // Upstream is blocked here, so only the skid beat can advance.
                if (out_xfer) begin
                    state_d    = ST_BUSY;
                    out_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_skid_buffer.sv
// Directed and random checks of the skid buffer against an in-order expected queue.
module tb_axi_skid_buffer;
    import axi_skid_buffer_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic         ready_out;
    logic         valid_out;
    logic [W-1:0] data_out;
    logic         ready_in;
    skid_state_e  state_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic         prev_stall;
    logic [W-1:0] prev_data;

    axi_skid_buffer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .state_o   (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        valid_in = v;
        data_in  = d;
        ready_in = r;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [W-1:0] d, input logic rdy);
        check({tag, "_valid"}, 32'(valid_out), 32'(v));
        check({tag, "_data"},  32'(data_out),  32'(d));
        check({tag, "_ready"}, 32'(ready_out), 32'(rdy));
    endtask

    // scoreboard: sampled mid-cycle, so it sees the handshake the next edge will act on
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
            prev_data  = '0;
        end else begin
            check("occ_valid", 32'(valid_out), 32'(exp_q.size() != 0));
            check("occ_ready", 32'(ready_out), 32'(exp_q.size() < 2));
            if (prev_stall) begin
                check("stable_valid", 32'(valid_out), 32'd1);
                check("stable_data",  32'(data_out),  32'(prev_data));
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            if (valid_in && ready_out) exp_q.push_back(data_in);
            check("occupancy", 32'(exp_q.size() <= 2), 32'd1);
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
        end
    end

    logic [W-1:0] stream_vals [4];

    initial begin
        stream_vals[0] = 8'h11;
        stream_vals[1] = 8'h22;
        stream_vals[2] = 8'h33;
        stream_vals[3] = 8'h44;
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        expect_out("por", 1'b0, 8'h00, 1'b0);
        check("por_state", 32'(state_o), 32'(ST_EMPTY));
        reset = 1'b0;
        #1;
        check("rel_ready", 32'(ready_out), 32'd1);
        check("rel_valid", 32'(valid_out), 32'd0);

        // streaming at full rate
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream_vals[i], 1'b1);
            tick();
            expect_out("stream", 1'b1, stream_vals[i], 1'b1);
        end
        drive(1'b0, 8'h99, 1'b1);
        tick();
        expect_out("stream_drain", 1'b0, 8'h44, 1'b1);

        // backpressure
        drive(1'b1, 8'hA0, 1'b1);
        tick();
        expect_out("bp_a0", 1'b1, 8'hA0, 1'b1);
        drive(1'b1, 8'hA1, 1'b1);
        tick();
        expect_out("bp_a1", 1'b1, 8'hA1, 1'b1);
        drive(1'b1, 8'hA2, 1'b0);
        tick();
        expect_out("bp_skid", 1'b1, 8'hA1, 1'b0);
        check("bp_state", 32'(state_o), 32'(ST_FULL));
        drive(1'b1, 8'hA3, 1'b0);
        tick();
        expect_out("bp_hold", 1'b1, 8'hA1, 1'b0);
        drive(1'b1, 8'hA3, 1'b1);
        tick();
        expect_out("bp_rel_a2", 1'b1, 8'hA2, 1'b1);
        tick();
        expect_out("bp_rel_a3", 1'b1, 8'hA3, 1'b1);
        drive(1'b1, 8'hA4, 1'b1);
        tick();
        expect_out("bp_rel_a4", 1'b1, 8'hA4, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("bp_drain", 1'b0, 8'hA4, 1'b1);

        // bubbles
        drive(1'b1, 8'h05, 1'b1);
        tick();
        expect_out("bub_05", 1'b1, 8'h05, 1'b1);
        drive(1'b0, 8'hFF, 1'b1);
        tick();
        expect_out("bub_gap0", 1'b0, 8'h05, 1'b1);
        drive(1'b1, 8'h06, 1'b1);
        tick();
        expect_out("bub_06", 1'b1, 8'h06, 1'b1);
        drive(1'b0, 8'hEE, 1'b1);
        tick();
        expect_out("bub_gap1", 1'b0, 8'h06, 1'b1);
        tick();
        expect_out("bub_idle", 1'b0, 8'h06, 1'b1);

        // simultaneous stall and arrival
        drive(1'b1, 8'h7D, 1'b1);
        tick();
        expect_out("sim_busy", 1'b1, 8'h7D, 1'b1);
        drive(1'b1, 8'h7E, 1'b0);
        tick();
        expect_out("sim_full", 1'b1, 8'h7D, 1'b0);
        drive(1'b1, 8'h7F, 1'b1);
        tick();
        expect_out("sim_7e", 1'b1, 8'h7E, 1'b1);
        tick();
        expect_out("sim_7f", 1'b1, 8'h7F, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("sim_drain", 1'b0, 8'h7F, 1'b1);

        // mid-stream reset with both registers full
        drive(1'b1, 8'hC0, 1'b1);
        tick();
        drive(1'b1, 8'hC1, 1'b0);
        tick();
        check("rst_pre_state", 32'(state_o), 32'(ST_FULL));
        #2;
        reset = 1'b1;
        #1;
        expect_out("rst_mid", 1'b0, 8'h00, 1'b0);
        check("rst_skid_data", 32'(dut.skid_data_q), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        #1;
        expect_out("rst_rel", 1'b0, 8'h00, 1'b1);

        // random traffic, scoreboard checks ordering and stability
        for (int i = 0; i < 1000; i++) begin
            drive(1'(($urandom_range(0, 3)) != 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        check("final_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_skid_buffer.md
Name: axi_skid_buffer

Overview:
- Single-stage, fully registered AXI-Stream-style skid buffer: valid/ready/data register slice between an upstream producer and a downstream consumer.
- Breaks the combinational ready path and the forward valid/data path while sustaining 1 transfer/cycle.
- Holds one extra "skid" beat so upstream may send one beat after downstream deasserts ready.
- Used on any pipeline boundary that needs timing isolation without throughput loss.

Parameters:
- DATA_WIDTH, 8, width in bits of data_in/data_out (legal: >=1).

Ports:
- clk  in  1  rising-edge clock; sole clock domain.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  upstream beat valid.
- data_in  in  DATA_WIDTH  upstream beat payload.
- ready_out  out  1  buffer can accept a beat (to upstream ready).
- valid_out  out  1  downstream beat valid.
- data_out  out  DATA_WIDTH  downstream beat payload.
- ready_in  in  1  downstream consumer ready.

Behaviour:
- Upstream transfer: valid_in && ready_out at a rising edge. Downstream transfer: valid_out && ready_in at a rising edge.
- Storage: output register (out_valid, out_data) drives valid_out/data_out directly. Skid register (skid_valid, skid_data) holds one overflow beat.
- States:
  - EMPTY: out_valid=0, skid_valid=0.
  - BUSY: out_valid=1, skid_valid=0.
  - FULL: out_valid=1, skid_valid=1.
- ready_out = !skid_valid && !reset. Fully registered: no combinational path from ready_in to ready_out.
- Transitions (in = upstream transfer, out = downstream transfer):
  - EMPTY + in -> BUSY; out register loads data_in.
  - BUSY + in + out -> BUSY; out register loads data_in.
  - BUSY + out only -> EMPTY.
  - BUSY + in, no out -> FULL; skid register captures data_in, out register holds.
  - BUSY, neither -> BUSY, hold.
  - FULL + out -> BUSY; out register loads skid_data, skid cleared. No upstream accept is possible in FULL.
  - FULL, no out -> hold.
- Latency: a beat accepted at edge N appears on valid_out/data_out after edge N (1 cycle), provided the output is free.
- Throughput: 1 beat/cycle while ready_in stays high.
- Ordering: strict FIFO order, no loss, no duplication.
- AXI stability: while valid_out && !ready_in, valid_out and data_out are held constant.
- valid_out never deasserts without a downstream transfer.
- When valid_in=0, data_in is ignored. data_out retains its last value when valid_out=0 (no clearing on drain).
- Reset: asynchronous assert. While reset is high:
  - valid_out=0, data_out=0, skid_valid=0, skid_data=0.
  - ready_out=0.
  - Any in-flight beats are discarded.
- After reset: first edge after deassertion behaves as EMPTY; ready_out=1 immediately after deassertion.
- Mid-operation reset (any state): immediately returns to the reset values above.
- Max occupancy 2 beats. ready_out drops exactly one cycle after the output stalls with a new beat arriving.

Decomposition:
- No shared package needed. Optionally a local state enum {EMPTY, BUSY, FULL}, which may equivalently be derived from the two valid flags.
- No sub-modules; one flat module. Reusable register-slice primitive not warranted.

Test Plan:
- Reset: assert reset mid-stream with both registers full -> valid_out=0, data_out=0, ready_out=0 immediately; after release ready_out=1, valid_out=0.
- Streaming: ready_in=1, valid_in=1, data_in 0x11,0x22,0x33,0x44 on consecutive edges -> data_out 0x11..0x44 on consecutive cycles, each 1 cycle after acceptance; ready_out stays 1.
- Backpressure: stream 0xA0,0xA1,0xA2, then drop ready_in while valid_in stays high.
  - -> the beat on data_out (0xA1) holds; next beat (0xA2) enters skid; ready_out=0 the following cycle.
  - Raise ready_in -> 0xA1, 0xA2, then new beats in order, with no gaps and nothing lost.
- Bubbles: valid_in toggles 1,0,1,0 with 0x05,0x06 and ready_in=1 -> valid_out pattern delayed 1 cycle; data_out 0x05 then 0x06; data_out holds 0x06 when idle.
- Simultaneous: state BUSY, ready_in=0 and valid_in=1 (0x7E) in the same cycle as a prior stall -> FULL.
  - Next cycle with ready_in=1 and valid_in=1 (0x7F) -> output 0x7E, 0x7F not accepted (ready_out=0); accepted the cycle after.
- Random: random valid_in/ready_in for 1000 cycles against a scoreboard queue -> exact in-order match, occupancy <=2, AXI stability never violated.
